// File: rtl/fan_tach_meter.sv
// Tachometer front end for one fan: synchronise and de-glitch the tach input, then count
// falling edges per window, measure the edge-to-edge period and flag stall/overflow.
module fan_tach_meter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned CNT_W       = 27,
    parameter int unsigned WIN_CNT     = 32'h2FAF07F,
    parameter int unsigned STALL_WINS  = 2
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             FAN_IN,
    input  logic             CLR,
    output logic [CNT_W-1:0] FAN_CNT,
    output logic             FAN_VLD,
    output logic [CNT_W-1:0] FAN_PERIOD,
    output logic             FAN_STALL,
    output logic             FAN_OVF
);

    localparam int unsigned RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned WIN_W = (WIN_CNT > 0) ? $clog2(WIN_CNT + 1) : 1;
    localparam int unsigned ZW    = $clog2(STALL_WINS + 1);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ZW-1:0]    Z_MAX    = ZW'(STALL_WINS);

    typedef enum logic [0:0] {StIdle, StArmed} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d, filt_dly_q;
    logic [RUN_W-1:0]       run_q, run_d;
    logic                   edge_evt_q, edge_evt_d;
    logic [WIN_W-1:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0]       ecnt_q, ecnt_d, ecnt_inc;
    logic [ZW-1:0]          zcnt_q, zcnt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   vld_q, vld_d;
    logic                   stall_q, stall_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       pcnt_q, pcnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   term;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Filtered level flips only after FILT_LEN consecutive disagreeing samples
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], FAN_IN};
        filt_d     = filt_q;
        run_d      = '0;
        if (s != filt_q) begin
            if (run_q == RUN_LAST) begin
                filt_d = s;
            end else begin
                run_d = run_q + 1'b1;
            end
        end
        edge_evt_d = filt_dly_q & ~filt_q;
    end

    always_comb begin
        term     = (wcnt_q == WIN_LAST);
        wcnt_d   = term ? '0 : wcnt_q + 1'b1;
        ecnt_inc = (edge_evt_q && (ecnt_q != CNT_MAX)) ? ecnt_q + 1'b1 : ecnt_q;
        ovf_d    = ovf_q | (edge_evt_q & (ecnt_q == CNT_MAX));
        ecnt_d   = term ? '0 : ecnt_inc;
        cnt_d    = term ? ecnt_inc : cnt_q;
        vld_d    = term;
        zcnt_d   = zcnt_q;
        stall_d  = stall_q;
        if (term) begin
            if (ecnt_inc == '0) begin
                zcnt_d = (zcnt_q == Z_MAX) ? zcnt_q : zcnt_q + 1'b1;
            end else begin
                zcnt_d = '0;
            end
            stall_d = (zcnt_d >= Z_MAX);
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= StIdle;
        end else if (CLR) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == StIdle && edge_evt_q) begin
            state_d = StArmed;
        end
    end

    // The first edge only arms the counter; FAN_PERIOD waits for a second edge
    always_comb begin
        pcnt_d   = '0;
        period_d = period_q;
        unique case (state_q)
            StIdle: begin
                if (edge_evt_q) begin
                    pcnt_d = CNT_W'(1);
                end
            end
            StArmed: begin
                if (edge_evt_q) begin
                    period_d = pcnt_q;
                    pcnt_d   = CNT_W'(1);
                end else begin
                    pcnt_d = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + 1'b1;
                end
            end
            default: pcnt_d = '0;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sync_q     <= '1;
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
            run_q      <= '0;
            edge_evt_q <= 1'b0;
            wcnt_q     <= '0;
            ecnt_q     <= '0;
            zcnt_q     <= '0;
            cnt_q      <= '0;
            vld_q      <= 1'b0;
            stall_q    <= 1'b0;
            ovf_q      <= 1'b0;
            pcnt_q     <= '0;
            period_q   <= '0;
        end else if (CLR) begin
            sync_q     <= '1;
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
            run_q      <= '0;
            edge_evt_q <= 1'b0;
            wcnt_q     <= '0;
            ecnt_q     <= '0;
            zcnt_q     <= '0;
            cnt_q      <= '0;
            vld_q      <= 1'b0;
            stall_q    <= 1'b0;
            ovf_q      <= 1'b0;
            pcnt_q     <= '0;
            period_q   <= '0;
        end else begin
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            run_q      <= run_d;
            edge_evt_q <= edge_evt_d;
            wcnt_q     <= wcnt_d;
            ecnt_q     <= ecnt_d;
            zcnt_q     <= zcnt_d;
            cnt_q      <= cnt_d;
            vld_q      <= vld_d;
            stall_q    <= stall_d;
            ovf_q      <= ovf_d;
            pcnt_q     <= pcnt_d;
            period_q   <= period_d;
        end
    end

    assign FAN_CNT    = cnt_q;
    assign FAN_VLD    = vld_q;
    assign FAN_PERIOD = period_q;
    assign FAN_STALL  = stall_q;
    assign FAN_OVF    = ovf_q;

endmodule
